// File: rtl/slice_scan_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : slice_scan_sequencer_pkg                                     |
// | Description : Shared state encoding, mode constants and a width helper    |
// |               for the slice scan sequencer and its dwell timer.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package slice_scan_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STATIC = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    localparam logic c_mode_static = 1'b0;
    localparam logic c_mode_scan   = 1'b1;

    // Counter width for a modulo-n counter; never below one bit so that a
    // dwell of a single cycle still yields a legal vector.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/slice_scan_sequencer_dwell_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : slice_scan_sequencer_dwell_timer                             |
// | Description : Modulo-DWELL_CYCLES counter with enable and clear. o_expire  |
// |               is high in the enabled cycle where the count is at its last  |
// |               value; the counter wraps to zero on that edge.               |
// | Ports       : clk, rst_n (async, active low), i_en, i_clr, o_expire        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module slice_scan_sequencer_dwell_timer
    import slice_scan_sequencer_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_expire
);

    localparam int unsigned          c_cnt_w = cnt_width(DWELL_CYCLES);
    localparam logic [c_cnt_w-1:0]   c_last  = c_cnt_w'(DWELL_CYCLES - 1);

    logic [c_cnt_w-1:0] r_count;

    assign o_expire = i_en && (r_count == c_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr || o_expire) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/slice_scan_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : slice_scan_sequencer                                         |
// | Description : Buffers an IN_W-bit word (one-entry pending register), cuts  |
// |               it into SLICE_W-bit slices and drives display/LED outputs    |
// |               statically (top/bottom slice) or by scanning every slice     |
// |               with a programmable dwell, MSB slice first.                  |
// | Ports       : clk, rst_n (async, active low)                               |
// |               in_valid/in_ready/in_data  - word input handshake            |
// |               mode (0 static, 1 scan), hold (freeze scan)                  |
// |               display_out, led_out, slice_idx, frame_done - registered     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module slice_scan_sequencer
    import slice_scan_sequencer_pkg::*;
#(
    parameter  int unsigned IN_W         = 32,
    parameter  int unsigned SLICE_W      = 16,
    parameter  int unsigned DWELL_CYCLES = 100_000_000,
    localparam int unsigned N_SLICES     = IN_W / SLICE_W,
    localparam int unsigned IDX_W        = $clog2(N_SLICES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_data,
    input  logic               mode,
    input  logic               hold,
    output logic [SLICE_W-1:0] display_out,
    output logic [SLICE_W-1:0] led_out,
    output logic [IDX_W-1:0]   slice_idx,
    output logic               frame_done
);

    generate
        if ((IN_W % SLICE_W) != 0 || N_SLICES < 2 || N_SLICES > SLICE_W) begin : g_bad_cfg
            $error("slice_scan_sequencer: IN_W must be a multiple of SLICE_W with 2 <= N_SLICES <= SLICE_W");
        end
    endgenerate

    localparam logic [IDX_W-1:0]   c_idx_top = IDX_W'(N_SLICES - 1);
    localparam logic [SLICE_W-1:0] c_one     = SLICE_W'(1);

    state_t             r_state, w_state_nxt;
    logic               r_pend_valid;
    logic [IN_W-1:0]    r_pend_data;
    logic [IN_W-1:0]    r_active;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [SLICE_W-1:0] r_display, r_led;
    logic [IDX_W-1:0]   r_slice_idx;
    logic               r_frame_done;

    logic               w_accept;
    logic               w_xfer;
    logic               w_frame_end;
    logic               w_scan_run;
    logic               w_scan_clr;
    logic               w_expire;
    logic [SLICE_W-1:0] w_slice_sel;

    assign in_ready    = !r_pend_valid;
    assign w_accept    = in_valid && !r_pend_valid;

    // The dwell counter only runs while actually scanning; any other
    // situation (idle, static, leaving scan) parks it at zero so a fresh
    // scan always starts with a full dwell.
    assign w_scan_run  = (r_state == ST_SCAN) && (mode == c_mode_scan) && !hold;
    assign w_scan_clr  = !((r_state == ST_SCAN) && (mode == c_mode_scan));

    slice_scan_sequencer_dwell_timer #(
        .DWELL_CYCLES (DWELL_CYCLES)
    ) u_dwell_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (w_scan_run),
        .i_clr    (w_scan_clr),
        .o_expire (w_expire)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state, slice index step and pending->active transfer
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_xfer      = 1'b0;
        w_frame_end = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (r_pend_valid) begin
                    w_xfer = 1'b1;
                    if (mode == c_mode_scan) begin
                        w_state_nxt = ST_SCAN;
                        w_idx_nxt   = c_idx_top;
                    end else begin
                        w_state_nxt = ST_STATIC;
                        w_idx_nxt   = '0;
                    end
                end
            end
            ST_STATIC: begin
                w_xfer = r_pend_valid;
                if (mode == c_mode_scan) begin
                    w_state_nxt = ST_SCAN;
                    w_idx_nxt   = c_idx_top;
                end
            end
            ST_SCAN: begin
                if (mode == c_mode_static) begin
                    w_xfer      = r_pend_valid;
                    w_state_nxt = ST_STATIC;
                    w_idx_nxt   = '0;
                end else if (w_expire) begin
                    if (r_idx == '0) begin
                        // Only a frame boundary may swap in the waiting word,
                        // so a frame is never shown half old, half new.
                        w_idx_nxt   = c_idx_top;
                        w_frame_end = 1'b1;
                        w_xfer      = r_pend_valid;
                    end else begin
                        w_idx_nxt   = r_idx - 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pending / active word registers and scan index
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_valid <= 1'b0;
            r_pend_data  <= '0;
            r_active     <= '0;
            r_idx        <= '0;
        end else begin
            // Accept and transfer are mutually exclusive: accepting needs an
            // empty pending slot, transferring needs a full one.
            if (w_accept) begin
                r_pend_valid <= 1'b1;
                r_pend_data  <= in_data;
            end else if (w_xfer) begin
                r_pend_valid <= 1'b0;
            end
            if (w_xfer) begin
                r_active <= r_pend_data;
            end
            r_idx <= w_idx_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Output registers: one edge behind the active word / scan index
    // ------------------------------------------------------------------
    assign w_slice_sel = r_active[int'(r_idx) * SLICE_W +: SLICE_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_display    <= '0;
            r_led        <= '0;
            r_slice_idx  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
            unique case (r_state)
                ST_STATIC: begin
                    r_display   <= r_active[IN_W-1 -: SLICE_W];
                    r_led       <= r_active[SLICE_W-1:0];
                    r_slice_idx <= '0;
                end
                ST_SCAN: begin
                    r_display   <= w_slice_sel;
                    r_led       <= c_one << r_idx;
                    r_slice_idx <= r_idx;
                end
                default: begin
                    r_display   <= '0;
                    r_led       <= '0;
                    r_slice_idx <= '0;
                end
            endcase
        end
    end

    assign display_out = r_display;
    assign led_out     = r_led;
    assign slice_idx   = r_slice_idx;
    assign frame_done  = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_slice_scan_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_slice_scan_sequencer                                      |
// | Description : Scoreboard bench. A reference model, written in terms of a   |
// |               word queue and a position-within-frame tick, pushes the      |
// |               expected registered outputs each clock; a monitor pops and   |
// |               compares them. Directed scenarios plus random traffic.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_slice_scan_sequencer;

    localparam int IN_W    = 32;
    localparam int SLICE_W = 16;
    localparam int DWELL   = 4;
    localparam int N       = IN_W / SLICE_W;
    localparam int IDX_W   = 1;
    localparam int FRAME   = N * DWELL;

    logic               clk      = 1'b0;
    logic               rst_n    = 1'b0;
    logic               in_valid = 1'b0;
    logic [IN_W-1:0]    in_data  = '0;
    logic               mode     = 1'b0;
    logic               hold     = 1'b0;
    logic               in_ready;
    logic [SLICE_W-1:0] display_out;
    logic [SLICE_W-1:0] led_out;
    logic [IDX_W-1:0]   slice_idx;
    logic               frame_done;

    slice_scan_sequencer #(
        .IN_W         (IN_W),
        .SLICE_W      (SLICE_W),
        .DWELL_CYCLES (DWELL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .mode        (mode),
        .hold        (hold),
        .display_out (display_out),
        .led_out     (led_out),
        .slice_idx   (slice_idx),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [SLICE_W-1:0] disp;
        logic [SLICE_W-1:0] led;
        logic [IDX_W-1:0]   idx;
        logic               fd;
        logic               rdy;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [SLICE_W-1:0] slice_of(input logic [IN_W-1:0] w, input int k);
        logic [IN_W-1:0] t;
        t = w >> (k * SLICE_W);
        return t[SLICE_W-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Reference model. m_state: 0 idle, 1 static, 2 scan. In scan, m_tick
    // is the position inside a frame (0..FRAME-1); the shown slice is
    // N-1 - tick/DWELL and the frame ends when the tick wraps.
    // ------------------------------------------------------------------
    int              m_state  = 0;
    bit              m_pv     = 1'b0;
    logic [IN_W-1:0] m_pend   = '0;
    logic [IN_W-1:0] m_active = '0;
    int              m_tick   = 0;

    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        int   cur;
        bit   acc;
        bit   xfer;
        if (!rst_n) begin
            m_state  = 0;
            m_pv     = 1'b0;
            m_pend   = '0;
            m_active = '0;
            m_tick   = 0;
            sb.delete();
        end else begin
            e = '0;
            if (m_state == 1) begin
                e.disp = slice_of(m_active, N - 1);
                e.led  = slice_of(m_active, 0);
            end else if (m_state == 2) begin
                cur    = N - 1 - m_tick / DWELL;
                e.disp = slice_of(m_active, cur);
                e.led  = 16'd1 << cur;
                e.idx  = IDX_W'(cur);
            end
            e.fd = (m_state == 2) && mode && !hold && (m_tick == FRAME - 1);

            acc  = in_valid && !m_pv;
            xfer = 1'b0;
            case (m_state)
                0: if (m_pv) begin
                    xfer    = 1'b1;
                    m_state = mode ? 2 : 1;
                    m_tick  = 0;
                end
                1: begin
                    xfer = m_pv;
                    if (mode) begin
                        m_state = 2;
                        m_tick  = 0;
                    end
                end
                default: begin
                    if (!mode) begin
                        xfer    = m_pv;
                        m_state = 1;
                        m_tick  = 0;
                    end else if (!hold) begin
                        if (m_tick == FRAME - 1) begin
                            m_tick = 0;
                            xfer   = m_pv;
                        end else begin
                            m_tick = m_tick + 1;
                        end
                    end
                end
            endcase
            if (xfer) begin
                m_active = m_pend;
                m_pv     = 1'b0;
            end
            if (acc) begin
                m_pend = in_data;
                m_pv   = 1'b1;
            end
            e.rdy = !m_pv;
            sb.push_back(e);
        end
    end

    // ------------------------------------------------------------------
    // Monitor: every clock the DUT presents a new registered output set.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && sb.size() > 0) begin
            e = sb.pop_front();
            check("display_out", 32'(display_out), 32'(e.disp));
            check("led_out",     32'(led_out),     32'(e.led));
            check("slice_idx",   32'(slice_idx),   32'(e.idx));
            check("frame_done",  32'(frame_done),  32'(e.fd));
            check("in_ready",    32'(in_ready),    32'(e.rdy));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Offers a word and returns at the negedge after the accepting edge.
    task automatic send(input logic [IN_W-1:0] w);
        int k;
        k = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && k < 64) begin
            @(negedge clk);
            k++;
        end
        if (k >= 64) begin
            total++;
            bad++;
            $display("FAIL send_timeout: word %h not accepted within 64 clocks", w);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        int fd_cnt;
        int hi_cnt;

        // 1. reset and quiet idle
        idle(2);
        check("reset_display", 32'(display_out), 32'h0);
        check("reset_led",     32'(led_out),     32'h0);
        check("reset_ready",   32'(in_ready),    32'h1);
        rst_n = 1'b1;
        idle(8);

        // 2. static display, two-clock latency
        mode = 1'b0;
        send(32'h01234567);
        idle(2);
        check("static1_display", 32'(display_out), 32'h0123);
        check("static1_led",     32'(led_out),     32'h4567);
        send(32'h89ABCDEF);
        idle(2);
        check("static2_display", 32'(display_out), 32'h89AB);
        check("static2_led",     32'(led_out),     32'hCDEF);
        idle(3);

        // 3. scan of the active word
        mode = 1'b1;
        send(32'h89ABCDEF);
        idle(2 * FRAME);
        fd_cnt = 0;
        hi_cnt = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (frame_done) fd_cnt++;
            if (display_out == 16'h89AB) hi_cnt++;
        end
        check("scan_frame_pulses", 32'(fd_cnt), 32'd2);
        check("scan_msb_cycles",   32'(hi_cnt), 32'(FRAME));

        // 4. mid-frame update, third word stalls behind it
        idle(3);
        send(32'h11112222);
        send(32'h33334444);
        idle(3 * FRAME);

        // 5. hold mid-slice
        idle(2);
        hold = 1'b1;
        idle(10);
        hold = 1'b0;
        idle(2 * FRAME);

        // 6. asynchronous reset mid-slice with a word pending
        send(32'h55556666);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("areset_display", 32'(display_out), 32'h0);
        check("areset_led",     32'(led_out),     32'h0);
        check("areset_idx",     32'(slice_idx),   32'h0);
        check("areset_ready",   32'(in_ready),    32'h1);
        idle(3);
        rst_n = 1'b1;
        idle(6);
        check("post_reset_display", 32'(display_out), 32'h0);
        check("post_reset_ready",   32'(in_ready),    32'h1);

        // 7. random traffic
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            in_data  = $urandom;
            hold     = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 39) == 0) mode = ~mode;
        end
        @(negedge clk);
        in_valid = 1'b0;
        hold     = 1'b0;
        idle(4 * FRAME);
        check("scoreboard_drained", 32'(sb.size() <= 1), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
